tape_line_in: RTL and testbench
===============================

Name: tape_line_in

Overview:
Conditions the raw 1-bit cassette line input (AUDIO_IN comparator pin) into a clean tape_in signal for the "Tape Input = Line" path. When that path is selected, tape_in replaces casdout at the dragoncoco core, and it also feeds the tape-monitor sound bit and the LED. The block synchronises and glitch-filters the input, applies optional inversion, and measures rising-edge periods. It flags carrier activity, which the top level uses for the LED and for turbo gating.

Parameters:
GLITCH_CYC, 250, consecutive stable cycles required before the filtered level changes (5 us at 50 MHz)
MIN_PER, 10000, minimum in-range rising-edge period in clk cycles (5 kHz)
MAX_PER, 100000, maximum in-range rising-edge period in clk cycles (500 Hz)
IDLE_CYC, 25000000, cycles without a rising edge before carrier is declared lost (0.5 s)
ARM_COUNT, 4, consecutive in-range periods required to declare carrier

Ports:
clk  input  1  system clock (clk_sys, 50 MHz)
reset  input  1  synchronous active-high reset
audio_in  input  1  raw asynchronous line-in comparator level
enable  input  1  tape path enable (driven by cas_relay); low forces the measurement logic idle
invert  input  1  1 = invert polarity of the filtered level
tape_in  output  1  filtered, polarity-corrected tape level
edge_stb  output  1  one-cycle pulse on each change of tape_in while enable=1
period  output  20  last measured rising-edge-to-rising-edge period, in clk cycles
period_vld  output  1  one-cycle pulse when period updates
active  output  1  carrier present

Behaviour:
- Reset (synchronous, active-high): all registers 0. tape_in=0, edge_stb=0, period=0, period_vld=0, active=0. FSM goes to IDLE and the filter counter is cleared. Reset overrides every other input in the same cycle.
- Synchroniser: two-flop chain on audio_in, giving sync. Nothing else samples audio_in.
- Glitch filter:
  - filt is the filtered level.
  - gcnt (width clog2(GLITCH_CYC+1)) increments each cycle that sync != filt, and clears to 0 in any cycle that sync == filt.
  - When gcnt == GLITCH_CYC-1 and sync != filt, filt toggles and gcnt clears.
  - Pulses shorter than GLITCH_CYC cycles never reach filt.
  - The filter runs regardless of enable.
- Output latency: a clean step on audio_in appears on tape_in exactly GLITCH_CYC+3 clk edges later (2 synchroniser stages + GLITCH_CYC + 1 output register).
- tape_in:
  - Registered as (filt ^ invert) & enable.
  - enable=0 gives tape_in=0.
  - Toggling invert flips tape_in on the next edge and produces no edge_stb.
- Edges:
  - rise/fall are derived from filt transitions after inversion.
  - edge_stb is registered, coincident with the tape_in change, and suppressed when enable=0.
- Period counter pcnt (20 bits):
  - Increments every cycle while enable=1 and saturates at 20'hFFFFF.
  - On a rising edge: if have_prev=1 and pcnt is not saturated, then period<=pcnt+1 and period_vld pulses in that cycle. In all cases pcnt<=0 and have_prev<=1.
  - Saturation clears have_prev, so the next rising edge only restarts the measurement.
  - enable=0 clears pcnt and have_prev and holds period at its last value.
- Carrier FSM (states IDLE, ARMING, ACTIVE); active=1 only in ACTIVE:
  - IDLE -> ARMING on the first rising edge with enable=1; armcnt<=0.
  - ARMING, on each period_vld:
    - If MIN_PER <= period value <= MAX_PER (inclusive), armcnt increments. Reaching ARM_COUNT moves to ACTIVE in the same cycle as the qualifying period_vld.
    - If the period is out of range, armcnt<=0 and the FSM stays in ARMING.
  - ARMING -> IDLE when the idle timer reaches IDLE_CYC.
  - ACTIVE stays ACTIVE on any edge, including out-of-range periods.
  - ACTIVE -> IDLE when the idle timer reaches IDLE_CYC or enable=0.
  - Idle timer: 25-bit counter, cleared on every rising edge and on state entry, saturating at IDLE_CYC.
  - enable=0 forces IDLE from any state on the next edge.
- Simultaneous events: a rising edge in the same cycle the idle timer reaches IDLE_CYC counts as an edge. The timer clears and the state is kept.
- Reset mid-measurement discards the partial period; no period_vld is emitted.

Test Plan:
- Reset + enable=1, audio_in held high -> tape_in rises exactly 253 clk edges after the step, with one edge_stb. active stays 0 and period_vld never pulses.
- Feed 100-cycle high glitches every 1000 cycles on a low line -> tape_in stays 0 and no edge_stb occurs. Then a 300-cycle pulse -> tape_in is high for 300 cycles.
- Feed a 1200 Hz square wave (41667-cycle period) -> the first period_vld appears on the 2nd rising edge with period=41667±1. active rises on the 5th rising edge (4th valid period).
- Active carrier with one 200000-cycle gap inserted -> active stays 1. Stopping the input for 25000000 cycles -> active falls exactly at IDLE_CYC after the last rising edge.
- In ARMING, alternate 41667 and 5000-cycle periods -> armcnt keeps clearing and active never asserts. Holding invert=1 -> tape_in is the complement of the line and period is still measured on the inverted rising edges.
- Drop enable during ACTIVE -> tape_in=0, active=0 and edge_stb is silent on the next edge. Re-enable: the first rising edge gives no period_vld. Asserting reset mid-period clears all outputs in one cycle.

Source files
------------

// File: rtl/tape_line_in_if.sv
// Signal bundle for the line-in tape conditioner: raw line level and controls in,
// conditioned level, edge/period strobes and carrier status out.
interface tape_line_in_if;
  // Strobe semantics: edge_stb and period_vld are one-cycle valid pulses with no
  // ready; a consumer must take period on the cycle period_vld is high, because
  // there is no back-pressure and the next rising edge overwrites it.
  logic        audio_in;
  logic        enable;
  logic        invert;
  logic        tape_in;
  logic        edge_stb;
  logic [19:0] period;
  logic        period_vld;
  logic        active;
  logic [1:0]  fsm_state;

  modport master (
    output audio_in, enable, invert,
    input  tape_in, edge_stb, period, period_vld, active, fsm_state
  );

  modport slave (
    input  audio_in, enable, invert,
    output tape_in, edge_stb, period, period_vld, active, fsm_state
  );
endinterface

// File: rtl/tape_line_in.sv
// Cassette line-in conditioner: synchronise, glitch-filter, optional inversion,
// rising-edge period measurement and carrier detection.
module tape_line_in #(
  parameter int GLITCH_CYC = 250,
  parameter int MIN_PER    = 10000,
  parameter int MAX_PER    = 100000,
  parameter int IDLE_CYC   = 25000000,
  parameter int ARM_COUNT  = 4
) (
  input logic          clk,
  input logic          reset,
  tape_line_in_if.slave bus
);

  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam int AW = $clog2(ARM_COUNT + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYC - 1);
  localparam logic [AW-1:0] A_LAST = AW'(ARM_COUNT - 1);
  localparam logic [19:0]   P_MIN  = 20'(MIN_PER);
  localparam logic [19:0]   P_MAX  = 20'(MAX_PER);
  localparam logic [19:0]   P_SAT  = 20'hFFFFF;
  localparam logic [24:0]   T_LAST = 25'(IDLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  logic          sync_a, sync;
  logic          filt, filt_d;
  logic [GW-1:0] gcnt;
  logic          tape_r, edge_r;
  logic [19:0]   pcnt, period_r;
  logic          have_prev, pvld_r;
  state_t        state;
  logic [AW-1:0] armcnt;
  logic [24:0]   tmr;
  logic          active_r;

  logic        rise, meas_vld, in_range;
  logic [19:0] meas_val;

  // A rise is a change of the filtered level that lands high after inversion;
  // toggling invert alone never counts because filt itself did not move.
  assign rise     = bus.enable & (filt != filt_d) & (filt ^ bus.invert);
  assign meas_vld = rise & have_prev & (pcnt != P_SAT);
  assign meas_val = pcnt + 20'd1;
  assign in_range = (meas_val >= P_MIN) && (meas_val <= P_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync   <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      gcnt   <= '0;
      tape_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_a <= bus.audio_in;
      sync   <= sync_a;
      filt_d <= filt;
      if (sync != filt) begin
        if (gcnt == G_LAST) begin
          filt <= ~filt;
          gcnt <= '0;
        end else begin
          gcnt <= gcnt + GW'(1);
        end
      end else begin
        gcnt <= '0;
      end
      tape_r <= (filt ^ bus.invert) & bus.enable;
      edge_r <= bus.enable & (filt != filt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt      <= '0;
      have_prev <= 1'b0;
      period_r  <= '0;
      pvld_r    <= 1'b0;
    end else begin
      pvld_r <= 1'b0;
      if (!bus.enable) begin
        pcnt      <= '0;
        have_prev <= 1'b0;
      end else if (rise) begin
        if (meas_vld) begin
          period_r <= meas_val;
          pvld_r   <= 1'b1;
        end
        pcnt      <= '0;
        have_prev <= 1'b1;
      end else if (pcnt != P_SAT) begin
        pcnt <= pcnt + 20'd1;
      end else begin
        // A saturated count is not a valid reference for the next edge.
        have_prev <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      state    <= IDLE;
      armcnt   <= '0;
      tmr      <= '0;
      active_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmr <= '0;
          if (rise) begin
            state  <= ARMING;
            armcnt <= '0;
          end
        end
        ARMING: begin
          if (rise) begin
            tmr <= '0;
            if (meas_vld) begin
              if (!in_range) begin
                armcnt <= '0;
              end else if (armcnt == A_LAST) begin
                state    <= ACTIVE;
                active_r <= 1'b1;
                armcnt   <= '0;
              end else begin
                armcnt <= armcnt + AW'(1);
              end
            end
          end else if (tmr == T_LAST) begin
            state <= IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 25'd1;
          end
        end
        ACTIVE: begin
          // Edges keep the carrier alive even when their period is out of range.
          if (rise) begin
            tmr <= '0;
          end else if (tmr == T_LAST) begin
            state    <= IDLE;
            active_r <= 1'b0;
            tmr      <= '0;
          end else begin
            tmr <= tmr + 25'd1;
          end
        end
        default: begin
          state    <= IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tape_in    = tape_r;
  assign bus.edge_stb   = edge_r;
  assign bus.period     = period_r;
  assign bus.period_vld = pvld_r;
  assign bus.active     = active_r;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_tape_line_in.sv
// Directed bench for tape_line_in with shortened timing parameters.
module tb_tape_line_in;

  localparam int G    = 8;
  localparam int MINP = 40;
  localparam int MAXP = 200;
  localparam int IDLE = 1000;
  localparam int ARM  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tape_line_in_if bus();

  tape_line_in #(
    .GLITCH_CYC(G),
    .MIN_PER(MINP),
    .MAX_PER(MAXP),
    .IDLE_CYC(IDLE),
    .ARM_COUNT(ARM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];
  int stb_cnt = 0, pv_cnt = 0, rise_cnt = 0, act_rises = 0;
  int cyc = 0, last_rise_cyc = 0, act_fall_cyc = 0, act_rise_at = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // monitor: counts strobes and scores every period_vld against exp_q
  initial begin
    logic tape_prev, act_prev;
    logic [19:0] w;
    tape_prev = 1'b0;
    act_prev  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (bus.edge_stb) stb_cnt++;
        if (bus.tape_in && !tape_prev) begin
          rise_cnt++;
          last_rise_cyc = cyc;
        end
        if (bus.active && !act_prev) begin
          act_rises++;
          act_rise_at = rise_cnt;
        end
        if (!bus.active && act_prev) act_fall_cyc = cyc;
        if (bus.period_vld) begin
          pv_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL period_unexpected got=%0d want=none", bus.period);
          end else begin
            w = exp_q.pop_front();
            check("period", int'(bus.period), int'(w));
          end
        end
      end
      tape_prev = bus.tape_in;
      act_prev  = bus.active;
    end
  end

  // driver tasks: inputs change at negedge+1, outputs are read there too
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(20);
  endtask

  task automatic hold_count(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.tape_in) hi++;
    end
  endtask

  task automatic square(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      bus.audio_in = 1'b1;
      step(hi);
      bus.audio_in = 1'b0;
      step(lo);
    end
  endtask

  typedef struct {
    logic a, en, inv;
    int   hold;
    logic tape;
    int   stb;
    int   pv;
    int   per;
    int   st;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int s0, p0, r0, a0, lat, hi, h;

    //            a     en    inv   hold tape  stb pv per st
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 20, 1'b1, 1, 0, 0,  1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 5,  1'b0, 0, 0, 0,  1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5,  1'b1, 0, 0, 0,  1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5,  1'b0, 0, 0, 0,  0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 20, 1'b0, 0, 0, 0,  0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 20, 1'b0, 0, 0, 0,  0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 5,  1'b1, 0, 0, 0,  0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 20, 1'b0, 1, 0, 0,  0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 20, 1'b1, 1, 0, 0,  1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 20, 1'b1, 1, 1, 20, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5,  1'b0, 0, 0, 0,  1};

    bus.audio_in = 1'b0;
    bus.enable   = 1'b1;
    bus.invert   = 1'b0;
    reset        = 1'b1;
    step(3);
    check("rst_tape_in", bus.tape_in, 0);
    check("rst_edge_stb", bus.edge_stb, 0);
    check("rst_period", bus.period, 0);
    check("rst_period_vld", bus.period_vld, 0);
    check("rst_active", bus.active, 0);
    check("rst_state", bus.fsm_state, 0);
    reset = 1'b0;
    step(5);

    // step latency through synchroniser, filter and output register
    s0 = stb_cnt;
    p0 = pv_cnt;
    lat = 0;
    bus.audio_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (bus.tape_in) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, G + 3);
    step(30);
    check("step_stb", stb_cnt - s0, 1);
    check("step_pv", pv_cnt - p0, 0);
    check("step_active", bus.active, 0);

    // short glitches are swallowed, a long pulse passes with its width intact
    bus.audio_in = 1'b0;
    do_reset();
    s0 = stb_cnt;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      bus.audio_in = 1'b1;
      hold_count(G - 1, h);
      hi += h;
      bus.audio_in = 1'b0;
      hold_count(43, h);
      hi += h;
    end
    check("glitch_hi", hi, 0);
    check("glitch_stb", stb_cnt - s0, 0);
    bus.audio_in = 1'b1;
    hold_count(20, h);
    hi = h;
    bus.audio_in = 1'b0;
    hold_count(40, h);
    hi += h;
    check("pulse_hi", hi, 20);
    check("pulse_stb", stb_cnt - s0, 2);

    // table: enable / invert interactions
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].pv != 0) exp_q.push_back(20'(tbl[i].per));
      s0 = stb_cnt;
      p0 = pv_cnt;
      bus.audio_in = tbl[i].a;
      bus.enable   = tbl[i].en;
      bus.invert   = tbl[i].inv;
      step(tbl[i].hold);
      check($sformatf("vec%0d_tape", i), bus.tape_in, tbl[i].tape);
      check($sformatf("vec%0d_stb", i), stb_cnt - s0, tbl[i].stb);
      check($sformatf("vec%0d_pv", i), pv_cnt - p0, tbl[i].pv);
      check($sformatf("vec%0d_state", i), bus.fsm_state, tbl[i].st);
    end
    bus.invert = 1'b0;
    bus.enable = 1'b1;
    bus.audio_in = 1'b0;

    // carrier arming: active on the 5th rising edge
    do_reset();
    r0 = rise_cnt;
    p0 = pv_cnt;
    repeat (5) exp_q.push_back(20'd100);
    square(50, 50, 6);
    check("arm_active", bus.active, 1);
    check("arm_state", bus.fsm_state, 2);
    check("arm_rise_idx", act_rise_at - r0, 5);
    check("arm_pv", pv_cnt - p0, 5);
    check("arm_period", bus.period, 100);

    // a gap shorter than the idle timeout keeps the carrier
    exp_q.push_back(20'd600);
    exp_q.push_back(20'd100);
    step(500);
    square(50, 50, 2);
    check("gap_active", bus.active, 1);
    check("gap_period", bus.period, 100);

    // line goes quiet: carrier drops exactly IDLE cycles after the last rise
    for (int k = 0; k < 3000; k++) begin
      if (!bus.active) break;
      step(1);
    end
    check("idle_fall", bus.active, 0);
    check("idle_time", act_fall_cyc - last_rise_cyc, IDLE);
    check("idle_state", bus.fsm_state, 0);

    // alternating in/out-of-range periods never arm
    do_reset();
    a0 = act_rises;
    p0 = pv_cnt;
    for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 0) ? 20'd100 : 20'd20);
    for (int i = 0; i < 5; i++) begin
      square(50, 50, 1);
      square(10, 10, 1);
    end
    check("alt_active", bus.active, 0);
    check("alt_act_rises", act_rises - a0, 0);
    check("alt_state", bus.fsm_state, 1);
    check("alt_pv", pv_cnt - p0, 9);
    step(IDLE + 100);
    check("alt_timeout_state", bus.fsm_state, 0);

    // inverted polarity: tape_in complements the line, periods on inverted rises
    bus.invert = 1'b1;
    s0 = stb_cnt;
    do_reset();
    check("inv_idle_tape", bus.tape_in, 1);
    check("inv_idle_stb", stb_cnt - s0, 0);
    check("inv_idle_state", bus.fsm_state, 0);
    p0 = pv_cnt;
    exp_q.push_back(20'd110);
    exp_q.push_back(20'd100);
    bus.audio_in = 1'b1;
    step(20);
    check("inv_high_tape", bus.tape_in, 0);
    bus.audio_in = 1'b0;
    step(80);
    check("inv_low_tape", bus.tape_in, 1);
    square(30, 70, 2);
    check("inv_pv", pv_cnt - p0, 2);
    check("inv_period", bus.period, 100);
    check("inv_state", bus.fsm_state, 1);
    bus.invert = 1'b0;

    // reset in the middle of a period discards it
    bus.audio_in = 1'b0;
    do_reset();
    repeat (6) exp_q.push_back(20'd100);
    square(50, 50, 6);
    bus.audio_in = 1'b1;
    step(30);
    check("pre_rst_tape", bus.tape_in, 1);
    check("pre_rst_active", bus.active, 1);
    reset = 1'b1;
    step(1);
    check("mid_rst_tape", bus.tape_in, 0);
    check("mid_rst_active", bus.active, 0);
    check("mid_rst_period", bus.period, 0);
    check("mid_rst_pv", bus.period_vld, 0);
    check("mid_rst_stb", bus.edge_stb, 0);
    check("mid_rst_state", bus.fsm_state, 0);
    reset = 1'b0;
    bus.audio_in = 1'b0;
    p0 = pv_cnt;
    exp_q.push_back(20'd100);
    step(20);
    square(50, 50, 2);
    step(5);
    check("post_rst_pv", pv_cnt - p0, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
